// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
//
// Takes one M-extension operation at a time and produces its result after a
// fixed number of cycles. Multiplies use shift-add (LSB of the multiplier
// first). Divides use restoring division (one quotient bit per cycle, MSB
// first). Both work on operand magnitudes, and the sign is fixed up in a
// final FIX cycle. A divide by zero and the signed-overflow divide are
// answered one edge after accept, without iterating.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload until then. in_ready is high
// only in IDLE. out_valid is high only in DONE, and out_result holds steady
// until out_ready is seen.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   in_op               RV32M funct3 (mul..remu)
//   in_a, in_b          rs1 / rs2 operands
//   flush               abandon the operation in flight
//   out_valid/out_ready result handshake
//   out_result          result word
//   busy                unit is not in IDLE
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Low half holds the multiplier or dividend and shifts out one bit per
  // cycle. The high half accumulates the product. For divides the low half
  // collects the quotient bits.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              accept;
  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   trial, diff;
  logic              qbit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    rem_d     = rem_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;

    // flush wins over a request arriving in the same cycle.
    accept = in_valid && (state_q == S_IDLE) && !flush;

    // Signedness by funct3. rs1 is signed for mul/mulh/mulhsu/div/rem.
    // rs2 is signed for mul/mulh/div/rem.
    a_signed = in_op[2] ? !in_op[0] : (in_op[1:0] != 2'b11);
    b_signed = in_op[2] ? !in_op[0] : !in_op[1];
    sa       = a_signed && in_a[XLEN-1];
    sb       = b_signed && in_b[XLEN-1];
    a_mag    = sa ? (~in_a + 1'b1) : in_a;
    b_mag    = sb ? (~in_b + 1'b1) : in_b;

    // One shift-add step. The carry out of the add lands in the top bit.
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};

    // One restoring-division step. A negative difference means the trial
    // remainder is kept and the quotient bit is 0.
    trial = {rem_q, acc_q[XLEN-1]};
    diff  = trial - {2'b00, b_q};
    qbit  = !diff[XLEN+1];

    prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rmd  = neg_rem_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = in_op;
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          cnt_d     = CW'(XLEN - 1);
          acc_d     = {{XLEN{1'b0}}, a_mag};
          b_d       = b_mag;
          rem_d     = '0;
          if (in_op[2] && (in_b == '0)) begin
            res_d   = in_op[1] ? in_a : ALL_ONES;
            state_d = S_DONE;
          end else if (in_op[2] && !in_op[0] && (in_a == INT_MIN) && (in_b == ALL_ONES)) begin
            res_d   = in_op[1] ? '0 : INT_MIN;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            rem_d             = qbit ? diff[XLEN:0] : trial[XLEN:0];
            acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], qbit};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2])                res_d = op_q[1] ? rmd : quo;
          else if (op_q[1:0] == 2'b00) res_d = prod[XLEN-1:0];
          else                        res_d = prod[2*XLEN-1:XLEN];
          state_d = S_DONE;
        end
      end
      default: begin  // S_DONE
        if (flush || out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      res_q     <= res_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;

endmodule
